tr_sram_reader: RTL

//  Test-runner-side initiator on the SRAM arbiter's tr_* master port. On start, streams word_count
//  16-bit words from SRAM beginning at base_addr, using pipelined reads with waitrequest

---
 rtl/tr_sram_reader_pkg.sv | 14 +
 rtl/tr_sram_reader_if.sv | 33 +++
 rtl/tr_sram_reader_fifo.sv | 60 ++++++
 rtl/tr_sram_reader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tr_sram_reader_pkg.sv
// Shared types and default widths for the test-runner SRAM reader.
package tr_pkg;

   localparam int unsigned TR_ADDR_W = 20;
   localparam int unsigned TR_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } tr_rd_state_e;

endpackage

// File: rtl/tr_sram_reader_if.sv
// SRAM arbiter tr_* master port plus the valid/ready output stream.
interface tr_sram_reader_if
   import tr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TR_ADDR_W,
   parameter int unsigned DATA_WIDTH = TR_DATA_W
);

   logic [ADDR_WIDTH-1:0] tr_address;
   logic [1:0]            tr_byteenable;
   logic                  tr_read;
   logic                  tr_write;
   logic [DATA_WIDTH-1:0] tr_writedata;
   logic                  tr_waitrequest;
   logic [DATA_WIDTH-1:0] tr_readdata;
   logic                  tr_readdataready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output tr_address, tr_byteenable, tr_read, tr_write, tr_writedata,
      output out_data, out_valid,
      input  tr_waitrequest, tr_readdata, tr_readdataready, out_ready
   );

   modport slave (
      input  tr_address, tr_byteenable, tr_read, tr_write, tr_writedata,
      input  out_data, out_valid,
      output tr_waitrequest, tr_readdata, tr_readdataready, out_ready
   );

endinterface

// File: rtl/tr_sram_reader_fifo.sv
// Show-ahead synchronous FIFO: head word is visible on dout whenever not empty.
module sync_fifo_fwft #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; flush empties the queue in one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array, left unreset.
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

   // Upstream credit accounting must never let a push hit a full queue.
   always_ff @(posedge clock) begin
      if (!reset) assert (!(push && full && !pop));
   end

endmodule

// File: rtl/tr_sram_reader.sv
// Streams word_count SRAM words from base_addr via pipelined reads into a show-ahead FIFO.
module tr_sram_reader
   import tr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TR_ADDR_W,
   parameter int unsigned DATA_WIDTH = TR_DATA_W,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_PEND   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  err,
   tr_sram_reader_if.master      bus
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned PW    = $clog2(MAX_PEND + 1);
   localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

   tr_rd_state_e          state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      issued_q;
   logic [PW-1:0]         pend_q, pend_nxt;
   logic                  abort_seen_q, abort_seen_nxt;
   logic                  held_q;

   logic                  req, accept, ret, pend_nz, credit, more, abort_any;
   logic                  push, pop, flush;
   logic [FCW-1:0]        fifo_count;
   logic                  fifo_empty, fifo_full;
   logic [DATA_WIDTH-1:0] fifo_dout;

   assign bus.tr_read       = req;
   assign bus.tr_address    = addr_q;
   assign bus.tr_byteenable = {2{req}};
   assign bus.tr_write      = 1'b0;
   assign bus.tr_writedata  = '0;
   assign bus.out_data      = fifo_dout;
   assign bus.out_valid     = ~fifo_empty;

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state, bus request, credit check and return routing.
   always_comb begin
      state_nxt      = state;
      req            = 1'b0;
      flush          = 1'b0;
      accept         = 1'b0;
      ret            = bus.tr_readdataready;
      pend_nz        = (pend_q != '0);
      more           = (issued_q < count_q);
      credit         = ((32'(pend_q) + 32'(fifo_count)) < FIFO_DEPTH) &&
                       (32'(pend_q) < MAX_PEND) && !fifo_full;
      abort_any      = (state != IDLE) && (abort_seen_q || abort);
      abort_seen_nxt = abort_seen_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt      = ISSUE;
               abort_seen_nxt = 1'b0;
            end
         end
         ISSUE: begin
            // A held request stays on the bus until accepted, even under abort.
            req    = held_q || (!abort_any && more && credit);
            accept = req && !bus.tr_waitrequest;
            if (abort) abort_seen_nxt = 1'b1;
            if (count_q == '0)
               state_nxt = FIN;
            else if (accept && (issued_q + CNT_W'(1) == count_q))
               state_nxt = DRAIN;
            else if (abort_any && !req)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (abort) abort_seen_nxt = 1'b1;
            if (!pend_nz) state_nxt = FIN;
         end
         FIN: begin
            flush     = abort_seen_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      push     = ret && pend_nz && !abort_any;
      pop      = !fifo_empty && bus.out_ready;
      pend_nxt = pend_q + PW'(accept) - PW'(ret && pend_nz);
   end

   // Transfer bookkeeping and registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q       <= '0;
         count_q      <= '0;
         issued_q     <= '0;
         pend_q       <= '0;
         abort_seen_q <= 1'b0;
         held_q       <= 1'b0;
         err          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            addr_q   <= base_addr;
            count_q  <= word_count;
            issued_q <= '0;
         end else if (accept) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + CNT_W'(1);
         end
         pend_q       <= pend_nxt;
         abort_seen_q <= abort_seen_nxt;
         held_q       <= req && bus.tr_waitrequest;
         if (ret && !pend_nz) err <= 1'b1;
         busy    <= (state_nxt != IDLE);
         done    <= (state_nxt == FIN);
         aborted <= (state_nxt == FIN) && abort_seen_nxt;
      end
   end

   sync_fifo_fwft #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (bus.tr_readdata),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
